// File: rtl/led_blink_sequencer.sv
// Sequencer for the LED blink-rate generator: debounced button plus mode input select between
// off, manual switch pass-through, and an auto mode that cycles the four rates on a dwell timer.
module led_blink_sequencer #(
  parameter int unsigned c_DWELL_CNT    = 48000,
  parameter int unsigned c_DEBOUNCE_CNT = 250
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_button,
  input  logic       i_mode,
  input  logic       i_sw_1,
  input  logic       i_sw_2,
  output logic       o_switch_1,
  output logic       o_switch_2,
  output logic       o_enable,
  output logic [1:0] o_state,
  output logic       o_step_pulse
);

  typedef enum logic [1:0] {
    SOff    = 2'b00,
    SManual = 2'b01,
    SAuto   = 2'b10,
    SHold   = 2'b11
  } state_e;

  localparam logic [31:0] DwellLast = 32'(c_DWELL_CNT - 1);
  localparam logic [31:0] DebLast   = 32'(c_DEBOUNCE_CNT - 1);

  // Button path
  logic [1:0]  sync_q;
  logic        deb_q, deb_d;
  logic        press_q, press_d;
  logic [31:0] deb_cnt_q, deb_cnt_d;

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync_q[1] != deb_q) begin
      // The edge that would bring the count to c_DEBOUNCE_CNT accepts the new level.
      if (deb_cnt_q == DebLast) begin
        deb_d = sync_q[1];
      end else begin
        deb_cnt_d = deb_cnt_q + 32'd1;
      end
    end
    press_d = deb_d & ~deb_q;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_q    <= 2'b00;
      deb_q     <= 1'b0;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], i_button};
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      press_q   <= press_d;
    end
  end

  // Sequencer FSM
  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] dwell_q, dwell_d;
  logic [1:0]  sel_q, sel_d;
  logic        en_q, en_d;
  logic        step_q, step_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    step_d  = 1'b0;
    unique case (state_q)
      SOff: begin
        idx_d   = 2'b00;
        dwell_d = '0;
        if (press_q) state_d = i_mode ? SAuto : SManual;
      end
      SManual: begin
        idx_d   = 2'b00;
        dwell_d = '0;
        if (press_q)     state_d = SOff;
        else if (i_mode) state_d = SAuto;
      end
      SAuto: begin
        if (!press_q && !i_mode) begin
          state_d = SManual;
        end else begin
          // A press on the terminal cycle still takes the step before holding.
          if (dwell_q == DwellLast) begin
            dwell_d = '0;
            idx_d   = idx_q + 2'd1;
            step_d  = 1'b1;
          end else begin
            dwell_d = dwell_q + 32'd1;
          end
          if (press_q) state_d = SHold;
        end
      end
      SHold: begin
        if (press_q)      state_d = SAuto;
        else if (!i_mode) state_d = SManual;
      end
      default: state_d = SOff;
    endcase

    en_d = (state_d != SOff);
    unique case (state_d)
      SOff:    sel_d = 2'b00;
      SManual: sel_d = {i_sw_1, i_sw_2};
      default: sel_d = idx_d;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= SOff;
      idx_q   <= 2'b00;
      dwell_q <= '0;
      sel_q   <= 2'b00;
      en_q    <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dwell_q <= dwell_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      step_q  <= step_d;
    end
  end

  assign o_switch_1   = sel_q[1];
  assign o_switch_2   = sel_q[0];
  assign o_enable     = en_q;
  assign o_state      = state_q;
  assign o_step_pulse = step_q;

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Bench for led_blink_sequencer: directed scenarios with literal expectations plus a random
// phase, all checked every cycle against a behavioural model of the sequencer.
module tb_led_blink_sequencer;

  localparam int Dwell = 8;
  localparam int Deb   = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       button = 1'b0;
  logic       mode = 1'b0;
  logic       sw1 = 1'b0;
  logic       sw2 = 1'b0;
  logic       out_sw1, out_sw2, out_en, out_pulse;
  logic [1:0] out_state;

  int checks = 0;
  int failures = 0;
  int pulse_cnt = 0;

  led_blink_sequencer #(
    .c_DWELL_CNT   (Dwell),
    .c_DEBOUNCE_CNT(Deb)
  ) dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_button    (button),
    .i_mode      (mode),
    .i_sw_1      (sw1),
    .i_sw_2      (sw2),
    .o_switch_1  (out_sw1),
    .o_switch_2  (out_sw2),
    .o_enable    (out_en),
    .o_state     (out_state),
    .o_step_pulse(out_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. hist[k] is the raw button sampled k edges ago; the debounced level flips
  // once Deb consecutive synchronized samples (two edges of latency) disagree with it.
  int hist[0:Deb+1];
  int m_deb = 0;
  int m_press_pend = 0;
  int m_state = 0;
  int m_elapsed = 0;
  int m_sel = 0;
  int m_en = 0;
  int m_pulse = 0;

  always @(posedge clk or negedge rst_n) begin
    int press;
    int flip;
    int step;
    if (!rst_n) begin
      for (int k = 0; k <= Deb + 1; k++) hist[k] = 0;
      m_deb = 0;
      m_press_pend = 0;
      m_state = 0;
      m_elapsed = 0;
      m_sel = 0;
      m_en = 0;
      m_pulse = 0;
    end else begin
      press = m_press_pend;
      for (int k = Deb + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'(button);
      flip = 1;
      for (int k = 2; k <= Deb + 1; k++) if (hist[k] == m_deb) flip = 0;
      m_press_pend = 0;
      if (flip == 1) begin
        m_deb = 1 - m_deb;
        m_press_pend = m_deb;
      end

      step = 0;
      case (m_state)
        0: if (press == 1) begin
          m_state = mode ? 2 : 1;
          m_elapsed = 0;
        end
        1: if (press == 1) m_state = 0;
           else if (mode) begin
             m_state = 2;
             m_elapsed = 0;
           end
        2: if (press == 0 && !mode) m_state = 1;
           else begin
             m_elapsed++;
             if (m_elapsed % Dwell == 0) step = 1;
             if (press == 1) m_state = 3;
           end
        default: if (press == 1) m_state = 2;
                 else if (!mode) m_state = 1;
      endcase

      m_en = (m_state != 0) ? 1 : 0;
      m_pulse = step;
      if (m_state == 0) m_sel = 0;
      else if (m_state == 1) m_sel = {30'd0, sw1, sw2};
      else m_sel = (m_elapsed / Dwell) % 4;
    end
  end

  always @(negedge clk) begin
    chk("state", int'(out_state), m_state);
    chk("enable", int'(out_en), m_en);
    chk("select", int'({out_sw1, out_sw2}), m_sel);
    chk("step_pulse", int'(out_pulse), m_pulse);
    if (out_pulse) pulse_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_out(input string name, input int st, input int en, input int sel);
    chk({name, "_state"}, int'(out_state), st);
    chk({name, "_enable"}, int'(out_en), en);
    chk({name, "_select"}, int'({out_sw1, out_sw2}), sel);
  endtask

  // Clean press and release, long enough for both edges to debounce.
  task automatic press_release();
    button = 1'b1;
    tick(Deb + 3);
    button = 1'b0;
    tick(Deb + 2);
  endtask

  int hold_cnt;

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    chk_out("in_reset", 0, 0, 0);
    chk("in_reset_pulse", int'(out_pulse), 0);
    rst_n = 1'b1;
    tick(100);
    chk_out("idle_off", 0, 0, 0);
    chk("idle_no_pulse", pulse_cnt, 0);

    // Short glitch must not press
    button = 1'b1;
    tick(3);
    button = 1'b0;
    tick(10);
    chk("glitch_state", int'(out_state), 0);

    // Manual entry exactly at edge N+6
    mode = 1'b0;
    {sw1, sw2} = 2'b10;
    button = 1'b1;
    tick(Deb + 2);
    chk("press_early_state", int'(out_state), 0);
    tick(1);
    chk_out("manual_entry", 1, 1, 2);
    button = 1'b0;
    tick(Deb + 2);
    {sw1, sw2} = 2'b01;
    tick(1);
    chk("manual_sw_follow", int'({out_sw1, out_sw2}), 1);

    press_release();
    chk("back_off_state", int'(out_state), 0);

    // Auto sequence 00,01,10,11,00
    mode = 1'b1;
    button = 1'b1;
    tick(Deb + 3);
    chk_out("auto_entry", 2, 1, 0);
    button = 1'b0;
    tick(Dwell - 1);
    chk("auto_dwell0", int'({out_sw1, out_sw2}), 0);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      chk("auto_step_sel", int'({out_sw1, out_sw2}), k % 4);
      chk("auto_step_pulse", int'(out_pulse), 1);
      tick(Dwell - 1);
    end

    // Hold at dwell count 5, index 10
    tick(7);
    button = 1'b1;
    tick(Deb + 3);
    chk_out("hold_entry", 3, 1, 2);
    button = 1'b0;
    tick(50);
    chk_out("hold_frozen", 3, 1, 2);
    button = 1'b1;
    tick(Deb + 3);
    chk_out("resume", 2, 1, 2);
    button = 1'b0;
    tick(2);
    chk("resume_pre_step", int'({out_sw1, out_sw2}), 2);
    tick(1);
    chk("resume_step_sel", int'({out_sw1, out_sw2}), 3);
    chk("resume_step_pulse", int'(out_pulse), 1);

    // Press aligned with dwell terminal
    tick(1);
    button = 1'b1;
    tick(Deb + 3);
    chk_out("term_press", 3, 1, 0);
    chk("term_press_pulse", int'(out_pulse), 1);
    button = 1'b0;
    tick(Deb + 2);

    // Press wins over mode 1->0 in hold
    button = 1'b1;
    tick(Deb + 2);
    mode = 1'b0;
    tick(1);
    chk("press_over_mode", int'(out_state), 2);
    tick(1);
    chk("mode_to_manual", int'(out_state), 1);
    button = 1'b0;
    tick(Deb + 2);

    // Reset mid-cycle while auto at index 11
    mode = 1'b1;
    tick(1);
    tick(3 * Dwell);
    chk_out("pre_reset", 2, 1, 3);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_reset", 0, 0, 0);
    chk("async_reset_pulse", int'(out_pulse), 0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk_out("after_reset", 0, 0, 0);

    // Random phase
    hold_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (hold_cnt == 0) begin
        button = 1'($urandom_range(0, 1));
        hold_cnt = $urandom_range(1, 12);
      end else begin
        hold_cnt--;
      end
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 9) == 0) {sw1, sw2} = 2'($urandom_range(0, 3));
    end
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_blink_sequencer.md
# led_blink_sequencer

Controller that sequences the LED blink-rate generator. It owns the generator's rate-select pair and enable, and drives them from a debounced push-button and a mode input. In manual mode it passes through user switches. In auto mode it steps through the four rates on a fixed dwell timer, with pause and resume from the button. It sits between board I/O (button, switches) and the blink generator's select and enable inputs.

## Interface
- c_DWELL_CNT, 48000: clock cycles spent on each rate in auto mode (≥2).
- c_DEBOUNCE_CNT, 250: consecutive stable cycles required to accept a button level change (≥2).
- i_clock  in  1  system clock; all logic on rising edge.
- i_reset_n  in  1  reset, asynchronous assert, active-low. This polarity and synchronicity are fixed.
- i_button  in  1  raw push-button, asynchronous, active-high.
- i_mode  in  1  0 = manual, 1 = auto; quasi-static, synchronous to i_clock.
- i_sw_1, i_sw_2  in  1 each  manual rate select; synchronous, quasi-static.
- o_switch_1, o_switch_2  out  1 each  rate select to the generator: 00 = 100 Hz, 01 = 50 Hz, 10 = 10 Hz, 11 = 1 Hz.
- o_enable  out  1  generator enable.
- o_state  out  2  current FSM state encoding.
- o_step_pulse  out  1  one-cycle pulse on each auto-mode rate step.

## Operation
- **Button path**
  - 2-flop synchronizer.
  - Debounce counter counts cycles in which the synchronized level differs from the debounced level. It clears whenever they match.
  - When the count reaches c_DEBOUNCE_CNT, the debounced level takes the new value.
  - A press is a one-cycle pulse on the debounced 0→1 transition. Release generates nothing.
- **FSM states** (o_state encoding)
  - S_OFF = 00
    - o_enable = 0, selects = 00.
    - Press with i_mode = 1 → S_AUTO; press with i_mode = 0 → S_MANUAL.
  - S_MANUAL = 01
    - o_enable = 1, o_switch = {i_sw_1, i_sw_2}, registered.
    - Press → S_OFF.
    - i_mode = 1 → S_AUTO.
  - S_AUTO = 10
    - o_enable = 1, selects = index.
    - Dwell counter runs 0..c_DWELL_CNT−1. At terminal count: counter → 0, index += 1 (mod 4: 00→01→10→11→00), o_step_pulse = 1.
    - Press → S_HOLD.
    - i_mode = 0 → S_MANUAL.
  - S_HOLD = 11
    - o_enable = 1, index and dwell counter frozen (values retained).
    - Press → S_AUTO, counting resumes from the retained value.
    - i_mode = 0 → S_MANUAL.
- **Entering S_AUTO**
  - From S_OFF or S_MANUAL: dwell counter cleared, index cleared to 00.
  - From S_HOLD: nothing cleared.
- **Simultaneous events**
  - Press has priority over an i_mode change in the same cycle.
  - In S_AUTO, dwell terminal and press in the same cycle: the step is taken (index advances, pulse asserted) and the state goes to S_HOLD.
- **Width rules**
  - Dwell and debounce counters are 32-bit unsigned.
  - Index is 2-bit and wraps naturally.
- **Reset**
  - All outputs 0; o_state = 00 (S_OFF).
  - Counters, index, synchronizer and debounced level all 0.
  - Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.

## Timing
- All outputs are registered. They are decoded from the next state and index, so they change on the same edge as o_state.
- **Button latency**: if edge N is the first to sample the new raw level into sync stage 1:
  - debounced level updates at edge N+1+c_DEBOUNCE_CNT;
  - press pulse is high in the following cycle;
  - state and outputs update at edge N+2+c_DEBOUNCE_CNT.
- A glitch shorter than c_DEBOUNCE_CNT cycles after sync produces no press.
- **Auto stepping**: selects change every c_DWELL_CNT cycles. o_step_pulse is high for exactly the cycle in which the new select first appears.
- **Manual pass-through**: i_sw_* change visible on o_switch_* 1 cycle later.
- **Mode switch**: i_mode change is acted on at the next edge; outputs reflect the new state 1 cycle after i_mode changes.
- Release of i_reset_n takes effect on the first rising edge after deassertion.

## Test plan
Parameters for all scenarios: c_DWELL_CNT = 8, c_DEBOUNCE_CNT = 4.
- **Reset / off**: hold reset, then release with no button activity for 100 cycles → o_state = 00, o_enable = 0, o_switch = 00, o_step_pulse never asserted.
- **Debounce**:
  - 3-cycle button glitch → no state change.
  - Clean press with i_mode = 0, i_sw = 10 → S_MANUAL exactly at edge N+6, o_enable = 1, o_switch = 10.
  - Change i_sw to 01 → o_switch = 01 one cycle later.
- **Auto sequence**: press with i_mode = 1 → selects read 00 for 8 cycles, then 01, 10, 11, 00. Exactly one o_step_pulse per change, spaced 8 cycles apart.
- **Hold / resume**:
  - Press in S_AUTO at dwell count 5, index 10 → S_HOLD; selects stay 10 for 50 cycles with no pulses.
  - Press again → S_AUTO; step to 11 occurs 3 cycles later.
- **Simultaneous events**:
  - Press aligned with dwell terminal → index advances with a pulse, o_state = 11.
  - Press together with i_mode 1→0 in S_HOLD → S_AUTO, not S_MANUAL.
- **Reset mid-operation**: assert i_reset_n low in S_AUTO, index 11, mid-clock-cycle → all outputs 0 before the next edge; after release the bench stays in S_OFF.
